// File: rtl/seleccion_posicion_cursor_if.sv
// seleccion_posicion_cursor_if: button/mode inputs and board-image outputs of the cursor writer
interface seleccion_posicion_cursor_if;
  logic colocar;
  logic btn_arriba;
  logic btn_abajo;
  logic btn_izq;
  logic btn_der;
  logic btn_confirmar;
  logic [2:0] tamano_barco;
  logic orientacion;
  logic [1:0][4:0][4:0] matriz_posicion;
  logic [2:0] fila;
  logic [2:0] columna;
  logic listo;
  logic error;
  logic [4:0] confirmados;
  modport master (
    output colocar, btn_arriba, btn_abajo, btn_izq, btn_der, btn_confirmar, tamano_barco, orientacion,
    input matriz_posicion, fila, columna, listo, error, confirmados
  );
  modport slave (
    input colocar, btn_arriba, btn_abajo, btn_izq, btn_der, btn_confirmar, tamano_barco, orientacion,
    output matriz_posicion, fila, columna, listo, error, confirmados
  );
endinterface

// File: rtl/seleccion_posicion_cursor.sv
// seleccion_posicion_cursor: cursor/ship preview over a 5x5 board with validated commits of previewed cells
module seleccion_posicion_cursor #(
  parameter int N = 5,
  parameter int TAM_MAX = 5
) (
  input logic clk,
  input logic rst,
  seleccion_posicion_cursor_if.slave cur
);
  typedef enum logic [1:0] {ESPERA, VALIDAR, COMMIT, RECHAZO} estado_t;
  estado_t estado, estado_n;
  logic [N-1:0][N-1:0] mapa, vista;
  logic [4:0] previo, botones, pulsado;
  logic colocar_q, cambio, esp, colision, fuera;
  logic act_arr, act_aba, act_izq, act_der;
  logic [2:0] len, lim_f, lim_c, fila_q, columna_q, fila_n, columna_n;
  logic [4:0] confirmados_q;
  logic [5:0] suma;
  logic listo_q, error_q;
  // bit order {confirmar, arriba, abajo, izq, der} matches action priority
  assign botones = {cur.btn_confirmar, cur.btn_arriba, cur.btn_abajo, cur.btn_izq, cur.btn_der};
  assign pulsado = botones & ~previo;
  assign cambio = cur.colocar != colocar_q;
  assign esp = estado == ESPERA;
  assign act_arr = esp & pulsado[3] & ~pulsado[4];
  assign act_aba = esp & pulsado[2] & ~|pulsado[4:3];
  assign act_izq = esp & pulsado[1] & ~|pulsado[4:2];
  assign act_der = esp & pulsado[0] & ~|pulsado[4:1];
  assign len = (cur.colocar && cur.tamano_barco != 3'd0 && int'(cur.tamano_barco) <= TAM_MAX) ? cur.tamano_barco : 3'd1;
  assign lim_f = cur.orientacion ? 3'(N) - len : 3'(N - 1);
  assign lim_c = cur.orientacion ? 3'(N - 1) : 3'(N) - len;
  assign fuera = fila_q > lim_f || columna_q > lim_c;
  assign suma = 6'(confirmados_q) + 6'(len);
  assign colision = |(mapa & vista);
  always_comb begin
    vista = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        vista[r][c] = cur.orientacion
          ? (c == int'(columna_q) && r >= int'(fila_q) && r < int'(fila_q) + int'(len))
          : (r == int'(fila_q) && c >= int'(columna_q) && c < int'(columna_q) + int'(len));
  end
  always_comb begin
    estado_n = cambio ? ESPERA
             : esp ? (pulsado[4] ? VALIDAR : ESPERA)
             : estado == VALIDAR ? (colision ? RECHAZO : COMMIT)
             : ESPERA;
    // clamping after a shape change outranks any move in the same cycle
    fila_n = cambio ? 3'd0
           : fuera ? (fila_q > lim_f ? lim_f : fila_q)
           : act_arr ? (fila_q == 3'd0 ? fila_q : fila_q - 3'd1)
           : act_aba && fila_q < lim_f ? fila_q + 3'd1
           : fila_q;
    columna_n = cambio ? 3'd0
              : fuera ? (columna_q > lim_c ? lim_c : columna_q)
              : act_izq ? (columna_q == 3'd0 ? columna_q : columna_q - 3'd1)
              : act_der && columna_q < lim_c ? columna_q + 3'd1
              : columna_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= ESPERA;
      mapa <= '0;
      confirmados_q <= '0;
      fila_q <= '0;
      columna_q <= '0;
      listo_q <= 1'b0;
      error_q <= 1'b0;
      previo <= '1;
      colocar_q <= cur.colocar;
    end else begin
      estado <= estado_n;
      fila_q <= fila_n;
      columna_q <= columna_n;
      previo <= botones;
      colocar_q <= cur.colocar;
      listo_q <= !cambio && estado == COMMIT;
      error_q <= !cambio && estado == RECHAZO;
      if (cambio) begin
        mapa <= '0;
        confirmados_q <= '0;
      end else if (estado == COMMIT) begin
        mapa <= mapa | vista;
        confirmados_q <= suma > 6'd25 ? 5'd25 : suma[4:0];
      end
    end
  end
  assign cur.matriz_posicion = {mapa, vista};
  assign cur.fila = fila_q;
  assign cur.columna = columna_q;
  assign cur.listo = listo_q;
  assign cur.error = error_q;
  assign cur.confirmados = confirmados_q;
endmodule

// File: tb/tb_seleccion_posicion_cursor.sv
// tb_seleccion_posicion_cursor: scenario tasks plus randomized ops checked against a board-level model
module tb_seleccion_posicion_cursor;
  typedef logic [1:0][4:0][4:0] img_t;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  bit mm [5][5];
  int mf, mc, mcnt;
  always #5 clk = ~clk;
  seleccion_posicion_cursor_if bus ();
  seleccion_posicion_cursor #(.N(5), .TAM_MAX(5)) dut (.clk(clk), .rst(rst), .cur(bus.slave));

  function automatic int eff_len();
    return (bus.colocar && bus.tamano_barco >= 1 && bus.tamano_barco <= 5) ? int'(bus.tamano_barco) : 1;
  endfunction

  function automatic int lim_f();
    return bus.orientacion ? 5 - eff_len() : 4;
  endfunction

  function automatic int lim_c();
    return bus.orientacion ? 4 : 5 - eff_len();
  endfunction

  function automatic img_t exp_img();
    img_t img = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        img[1][r][c] = mm[r][c];
    for (int i = 0; i < eff_len(); i++)
      if (bus.orientacion) begin
        if (mf + i < 5) img[0][mf + i][mc] = 1'b1;
      end else begin
        if (mc + i < 5) img[0][mf][mc + i] = 1'b1;
      end
    return img;
  endfunction

  function automatic bit collides();
    bit hit = 0;
    for (int i = 0; i < eff_len(); i++)
      hit |= bus.orientacion ? mm[mf + i][mc] : mm[mf][mc + i];
    return hit;
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < eff_len(); i++)
      if (bus.orientacion) mm[mf + i][mc] = 1; else mm[mf][mc + i] = 1;
    mcnt = (mcnt + eff_len() > 25) ? 25 : mcnt + eff_len();
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        mm[r][c] = 0;
    mf = 0;
    mc = 0;
    mcnt = 0;
  endfunction

  function automatic void model_move(int b);
    case (b)
      0: if (mf > 0) mf--;
      1: if (mf < lim_f()) mf++;
      2: if (mc > 0) mc--;
      3: if (mc < lim_c()) mc++;
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int b, logic v);
    case (b)
      0: bus.btn_arriba = v;
      1: bus.btn_abajo = v;
      2: bus.btn_izq = v;
      3: bus.btn_der = v;
      default: bus.btn_confirmar = v;
    endcase
  endtask

  task automatic press(int b);
    drive(b, 1'b1);
    tick();
    model_move(b);
    drive(b, 1'b0);
    tick();
  endtask

  task automatic set_shape(int t, bit o);
    bus.tamano_barco = 3'(t);
    bus.orientacion = o;
    tick();
    if (mf > lim_f()) mf = lim_f();
    if (mc > lim_c()) mc = lim_c();
  endtask

  task automatic set_mode(bit v);
    bus.colocar = v;
    tick();
    model_clear();
  endtask

  task automatic confirm_seq(output logic l1, output logic l2, output logic l3, output logic e2,
                             output logic e3, output img_t img, output logic [4:0] cnt);
    bus.btn_confirmar = 1'b1;
    tick();
    bus.btn_confirmar = 1'b0;
    tick();
    l1 = bus.listo;
    tick();
    l2 = bus.listo;
    e2 = bus.error;
    img = bus.matriz_posicion;
    cnt = bus.confirmados;
    tick();
    l3 = bus.listo;
    e3 = bus.error;
  endtask

  task automatic test_reset();
    bus.colocar = 1'b0;
    bus.btn_arriba = 1'b0;
    bus.btn_abajo = 1'b0;
    bus.btn_izq = 1'b0;
    bus.btn_der = 1'b1;
    bus.btn_confirmar = 1'b0;
    bus.tamano_barco = 3'd1;
    bus.orientacion = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    tick();
    total++; if (bus.columna !== 3'd0 || bus.fila !== 3'd0) begin bad++; $display("FAIL reset_cursor got %0d,%0d want 0,0", bus.fila, bus.columna); end
    total++; if (bus.listo !== 1'b0 || bus.error !== 1'b0) begin bad++; $display("FAIL reset_pulses got %b%b want 00", bus.listo, bus.error); end
    total++; if (bus.confirmados !== 5'd0) begin bad++; $display("FAIL reset_count got %0d want 0", bus.confirmados); end
    total++; if (bus.matriz_posicion !== exp_img()) begin bad++; $display("FAIL reset_image got %h want %h", bus.matriz_posicion, exp_img()); end
    bus.btn_der = 1'b0;
    tick();
  endtask

  task automatic test_moves();
    press(1); press(1); press(3); press(3); press(3);
    total++; if (bus.fila !== 3'd2 || bus.columna !== 3'd3) begin bad++; $display("FAIL moves_cursor got %0d,%0d want 2,3", bus.fila, bus.columna); end
    total++; if (bus.matriz_posicion !== exp_img()) begin bad++; $display("FAIL moves_image got %h want %h", bus.matriz_posicion, exp_img()); end
  endtask

  task automatic test_saturation();
    set_mode(1'b1);
    set_shape(3, 1'b0);
    for (int i = 0; i < 6; i++) press(3);
    total++; if (bus.columna !== 3'd2 || bus.fila !== 3'd0) begin bad++; $display("FAIL sat_cursor got %0d,%0d want 0,2", bus.fila, bus.columna); end
    total++; if (bus.matriz_posicion !== exp_img()) begin bad++; $display("FAIL sat_image got %h want %h", bus.matriz_posicion, exp_img()); end
  endtask

  task automatic test_commit();
    logic l1, l2, l3, e2, e3;
    img_t img;
    logic [4:0] cnt;
    confirm_seq(l1, l2, l3, e2, e3, img, cnt);
    model_commit();
    total++; if ({l1, l2, l3} !== 3'b010) begin bad++; $display("FAIL commit_listo got %b want 010", {l1, l2, l3}); end
    total++; if (e2 !== 1'b0 || e3 !== 1'b0) begin bad++; $display("FAIL commit_error got %b%b want 00", e2, e3); end
    total++; if (img !== exp_img()) begin bad++; $display("FAIL commit_image got %h want %h", img, exp_img()); end
    total++; if (cnt !== 5'd3) begin bad++; $display("FAIL commit_count got %0d want 3", cnt); end
  endtask

  task automatic test_reject();
    logic l1, l2, l3, e2, e3;
    img_t img;
    logic [4:0] cnt;
    set_shape(2, 1'b1);
    press(3);
    total++; if ({bus.matriz_posicion[1][0][3], bus.matriz_posicion[0][0][3]} !== 2'b11) begin bad++; $display("FAIL reject_overlap got %b want 11", {bus.matriz_posicion[1][0][3], bus.matriz_posicion[0][0][3]}); end
    confirm_seq(l1, l2, l3, e2, e3, img, cnt);
    total++; if ({e2, e3} !== 2'b10 || {l1, l2, l3} !== 3'b000) begin bad++; $display("FAIL reject_pulses got err=%b%b listo=%b want 10/000", e2, e3, {l1, l2, l3}); end
    total++; if (img !== exp_img() || cnt !== 5'(mcnt)) begin bad++; $display("FAIL reject_state got %h/%0d want %h/%0d", img, cnt, exp_img(), mcnt); end
  endtask

  task automatic test_hold();
    bus.btn_der = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    model_move(3);
    bus.btn_der = 1'b0;
    tick();
    total++; if (bus.columna !== 3'(mc) || mc != 4) begin bad++; $display("FAIL hold_once got %0d want 4", bus.columna); end
    press(2);
    bus.btn_arriba = 1'b1;
    bus.btn_der = 1'b1;
    tick();
    model_move(0);
    bus.btn_arriba = 1'b0;
    bus.btn_der = 1'b0;
    tick();
    total++; if (bus.fila !== 3'd0 || bus.columna !== 3'd3) begin bad++; $display("FAIL priority got %0d,%0d want 0,3", bus.fila, bus.columna); end
  endtask

  task automatic test_mode_abort();
    logic l1, l2, l3, e2, e3;
    img_t img;
    logic [4:0] cnt;
    set_shape(1, 1'b0);
    press(1); press(1);
    bus.btn_confirmar = 1'b1;
    tick();
    bus.btn_confirmar = 1'b0;
    tick();
    bus.colocar = 1'b0;
    model_clear();
    tick();
    total++; if (bus.listo !== 1'b0) begin bad++; $display("FAIL abort_listo got %b want 0", bus.listo); end
    total++; if (bus.matriz_posicion !== exp_img() || bus.confirmados !== 5'd0) begin bad++; $display("FAIL abort_state got %h/%0d want %h/0", bus.matriz_posicion, bus.confirmados, exp_img()); end
    total++; if (bus.fila !== 3'd0 || bus.columna !== 3'd0) begin bad++; $display("FAIL abort_cursor got %0d,%0d want 0,0", bus.fila, bus.columna); end
    tick();
    total++; if (bus.listo !== 1'b0 || bus.error !== 1'b0) begin bad++; $display("FAIL abort_late got %b%b want 00", bus.listo, bus.error); end
    press(3); press(1);
    confirm_seq(l1, l2, l3, e2, e3, img, cnt);
    model_commit();
    total++; if ({l1, l2, l3, e2} !== 4'b0100 || cnt !== 5'd1 || img !== exp_img()) begin bad++; $display("FAIL attack_commit got %b/%0d/%h want 0100/1/%h", {l1, l2, l3, e2}, cnt, img, exp_img()); end
  endtask

  task automatic test_random();
    logic l1, l2, l3, e2, e3;
    img_t img;
    logic [4:0] cnt;
    bit acc;
    set_mode(1'b1);
    for (int n = 0; n < 80; n++) begin
      int op = $urandom_range(0, 9);
      if (op < 6) press($urandom_range(0, 3));
      else if (op < 8) set_shape($urandom_range(0, 7), 1'($urandom_range(0, 1)));
      else begin
        acc = !collides();
        confirm_seq(l1, l2, l3, e2, e3, img, cnt);
        if (acc) model_commit();
        total++; if ({l1, l2, l3, e2, e3} !== {1'b0, acc, 1'b0, !acc, 1'b0}) begin bad++; $display("FAIL rand_pulses op%0d got %b want %b", n, {l1, l2, l3, e2, e3}, {1'b0, acc, 1'b0, !acc, 1'b0}); end
        total++; if (img !== exp_img() || cnt !== 5'(mcnt)) begin bad++; $display("FAIL rand_commit op%0d got %h/%0d want %h/%0d", n, img, cnt, exp_img(), mcnt); end
      end
      total++; if (bus.fila !== 3'(mf) || bus.columna !== 3'(mc)) begin bad++; $display("FAIL rand_cursor op%0d got %0d,%0d want %0d,%0d", n, bus.fila, bus.columna, mf, mc); end
      total++; if (bus.matriz_posicion !== exp_img()) begin bad++; $display("FAIL rand_image op%0d got %h want %h", n, bus.matriz_posicion, exp_img()); end
    end
  endtask

  task automatic test_reset_mid_commit();
    bit seen = 0;
    bus.btn_confirmar = 1'b1;
    tick();
    bus.btn_confirmar = 1'b0;
    tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= bus.listo | bus.error;
    end
    total++; if (seen) begin bad++; $display("FAIL rstmid_pulse got 1 want 0"); end
    total++; if (bus.matriz_posicion !== exp_img() || bus.confirmados !== 5'd0) begin bad++; $display("FAIL rstmid_state got %h/%0d want %h/0", bus.matriz_posicion, bus.confirmados, exp_img()); end
  endtask

  initial begin
    test_reset();
    test_moves();
    test_saturation();
    test_commit();
    test_reject();
    test_hold();
    test_mode_abort();
    test_random();
    test_reset_mid_commit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
